// File: rtl/uart_load_controller_pkg.sv
// Shared definitions for the UART program/data download path: FSM state
// encodings, byte/length widths and default memory geometry.
package uart_load_controller_pkg;

    localparam int DEFAULT_ISA_WIDTH = 32;
    localparam int DEFAULT_ROM_DEPTH = 14;
    localparam int UART_BYTE_WIDTH   = 8;
    localparam int LOAD_LEN_WIDTH    = 16;

    typedef enum logic [2:0] {
        LOAD_ST_IDLE  = 3'd0,
        LOAD_ST_REQ   = 3'd1,
        LOAD_ST_HDR0  = 3'd2,
        LOAD_ST_HDR1  = 3'd3,
        LOAD_ST_DATA  = 3'd4,
        LOAD_ST_WRITE = 3'd5,
        LOAD_ST_DONE  = 3'd6,
        LOAD_ST_ERROR = 3'd7
    } load_state_t;

    // The length header arrives low byte first.
    function automatic logic [LOAD_LEN_WIDTH-1:0] join_len(
        input logic [UART_BYTE_WIDTH-1:0] lo,
        input logic [UART_BYTE_WIDTH-1:0] hi
    );
        return {hi, lo};
    endfunction

endpackage

// File: rtl/uart_load_controller_if.sv
// Bundle between the download controller, the UART receiver, the hazard unit
// and the instruction/data memory upload port.
interface uart_load_controller_if
    import uart_load_controller_pkg::*;
#(
    parameter int ROM_DEPTH = DEFAULT_ROM_DEPTH,
    parameter int ISA_WIDTH = DEFAULT_ISA_WIDTH
);

    logic                       start_load;
    logic                       load_grant;
    logic                       rx_valid;
    logic [UART_BYTE_WIDTH-1:0] rx_data;
    logic                       load_req;
    logic                       uart_disable;
    logic                       uart_write_enable;
    logic [ISA_WIDTH-1:0]       uart_data;
    logic [ROM_DEPTH:0]         uart_addr;
    logic                       pc_reset;
    logic                       busy;
    logic                       error;
    logic [ROM_DEPTH+1:0]       words_loaded;

    // The controller drives the memory upload port, so it is the master.
    modport master (
        input  start_load, load_grant, rx_valid, rx_data,
        output load_req, uart_disable, uart_write_enable, uart_data, uart_addr,
               pc_reset, busy, error, words_loaded
    );

    modport slave (
        output start_load, load_grant, rx_valid, rx_data,
        input  load_req, uart_disable, uart_write_enable, uart_data, uart_addr,
               pc_reset, busy, error, words_loaded
    );

endinterface

// File: rtl/uart_load_controller_word_packer.sv
// Packs a little-endian byte stream into ISA_WIDTH words; word/word_ready are
// valid in the cycle the final byte of a word is presented.
module uart_word_packer
    import uart_load_controller_pkg::*;
#(
    parameter int ISA_WIDTH = DEFAULT_ISA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       byte_valid,
    input  logic [UART_BYTE_WIDTH-1:0] byte_data,
    output logic [ISA_WIDTH-1:0]       word,
    output logic                       word_ready
);

    localparam int BYTES   = ISA_WIDTH / UART_BYTE_WIDTH;
    localparam int CNT_W   = $clog2(BYTES);
    localparam int SHIFT_W = ISA_WIDTH - UART_BYTE_WIDTH;

    logic [CNT_W-1:0]   byte_cnt;
    logic [SHIFT_W-1:0] shift;

    assign word_ready = byte_valid && (byte_cnt == CNT_W'(BYTES - 1));
    // Earlier bytes sit in the low lanes; the arriving byte takes the top lane.
    assign word       = {byte_data, shift};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            shift    <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
        end else if (byte_valid) begin
            shift    <= {byte_data, shift[SHIFT_W-1:UART_BYTE_WIDTH]};
            byte_cnt <= word_ready ? '0 : byte_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_load_controller.sv
// Sequences a UART download into instruction/data memory: acquires the memory
// from the hazard unit, parses a word-count header, writes words, restarts the PC.
module uart_load_controller
    import uart_load_controller_pkg::*;
#(
    parameter int ROM_DEPTH      = DEFAULT_ROM_DEPTH,
    parameter int ISA_WIDTH      = DEFAULT_ISA_WIDTH,
    parameter int TIMEOUT_CYCLES = 10000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_load_controller_if.master bus
);

    localparam int ADDR_W  = ROM_DEPTH + 1;
    localparam int COUNT_W = ROM_DEPTH + 2;
    localparam int CMP_W   = (COUNT_W > LOAD_LEN_WIDTH) ? COUNT_W : LOAD_LEN_WIDTH;
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CMP_W-1:0]   MAX_WORDS  = CMP_W'(1) << ADDR_W;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    load_state_t                state;
    logic [UART_BYTE_WIDTH-1:0] len_lo;
    logic [LOAD_LEN_WIDTH-1:0]  len;
    logic [TIMER_W-1:0]         timer;

    logic                       load_req_q;
    logic                       uart_disable_q;
    logic                       write_q;
    logic                       pc_reset_q;
    logic                       busy_q;
    logic                       error_q;
    logic [ISA_WIDTH-1:0]       data_q;
    logic [ADDR_W-1:0]          addr_q;
    logic [COUNT_W-1:0]         words_q;

    logic [LOAD_LEN_WIDTH-1:0]  rx_len;
    logic [COUNT_W-1:0]         words_next;
    logic                       in_window;
    logic                       timing;
    logic                       last_word;
    logic                       abort;
    logic                       pack_valid;
    logic                       pack_clear;
    logic                       word_ready;
    logic [ISA_WIDTH-1:0]       word;

    assign rx_len     = join_len(len_lo, bus.rx_data);
    assign words_next = words_q + 1'b1;
    assign last_word  = (CMP_W'(words_next) == CMP_W'(len));

    assign in_window = (state == LOAD_ST_HDR0) || (state == LOAD_ST_HDR1) ||
                       (state == LOAD_ST_DATA) || (state == LOAD_ST_WRITE);
    assign timing    = (state == LOAD_ST_HDR0) || (state == LOAD_ST_HDR1) ||
                       (state == LOAD_ST_DATA);

    // A byte arriving on the expiry cycle beats the timeout.
    assign abort = (in_window && !bus.load_grant) ||
                   (timing && !bus.rx_valid && (timer == TIMER_LAST)) ||
                   ((state == LOAD_ST_HDR1) && bus.rx_valid && (CMP_W'(rx_len) > MAX_WORDS));

    // The byte seen during WRITE starts the next word unless the download ends there.
    assign pack_valid = bus.rx_valid && bus.load_grant &&
                        ((state == LOAD_ST_DATA) || ((state == LOAD_ST_WRITE) && !last_word));
    assign pack_clear = !((state == LOAD_ST_DATA) || (state == LOAD_ST_WRITE));

    uart_word_packer #(
        .ISA_WIDTH (ISA_WIDTH)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (pack_clear),
        .byte_valid (pack_valid),
        .byte_data  (bus.rx_data),
        .word       (word),
        .word_ready (word_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= LOAD_ST_IDLE;
            len_lo         <= '0;
            len            <= '0;
            timer          <= '0;
            load_req_q     <= 1'b0;
            uart_disable_q <= 1'b1;
            write_q        <= 1'b0;
            pc_reset_q     <= 1'b0;
            busy_q         <= 1'b0;
            error_q        <= 1'b0;
            data_q         <= '0;
            addr_q         <= '0;
            words_q        <= '0;
        end else begin
            write_q    <= 1'b0;
            pc_reset_q <= 1'b0;
            if (bus.rx_valid) begin
                timer <= '0;
            end else if (timing) begin
                timer <= timer + 1'b1;
            end

            if (abort) begin
                state          <= LOAD_ST_ERROR;
                error_q        <= 1'b1;
                uart_disable_q <= 1'b1;
                load_req_q     <= 1'b0;
                busy_q         <= 1'b0;
            end else begin
                unique case (state)
                    LOAD_ST_IDLE, LOAD_ST_ERROR: begin
                        if (bus.start_load) begin
                            state      <= LOAD_ST_REQ;
                            load_req_q <= 1'b1;
                            busy_q     <= 1'b1;
                            error_q    <= 1'b0;
                            words_q    <= '0;
                        end
                    end
                    LOAD_ST_REQ: begin
                        if (bus.load_grant) begin
                            state          <= LOAD_ST_HDR0;
                            uart_disable_q <= 1'b0;
                            timer          <= '0;
                        end
                    end
                    LOAD_ST_HDR0: begin
                        if (bus.rx_valid) begin
                            len_lo <= bus.rx_data;
                            state  <= LOAD_ST_HDR1;
                        end
                    end
                    LOAD_ST_HDR1: begin
                        if (bus.rx_valid) begin
                            len <= rx_len;
                            if (rx_len == '0) begin
                                state      <= LOAD_ST_DONE;
                                pc_reset_q <= 1'b1;
                            end else begin
                                state <= LOAD_ST_DATA;
                            end
                        end
                    end
                    LOAD_ST_DATA: begin
                        if (word_ready) begin
                            state   <= LOAD_ST_WRITE;
                            write_q <= 1'b1;
                            data_q  <= word;
                            addr_q  <= words_q[ADDR_W-1:0];
                        end
                    end
                    LOAD_ST_WRITE: begin
                        words_q <= words_next;
                        if (last_word) begin
                            state      <= LOAD_ST_DONE;
                            pc_reset_q <= 1'b1;
                        end else begin
                            state <= LOAD_ST_DATA;
                        end
                    end
                    LOAD_ST_DONE: begin
                        state          <= LOAD_ST_IDLE;
                        uart_disable_q <= 1'b1;
                        load_req_q     <= 1'b0;
                        busy_q         <= 1'b0;
                    end
                    default: state <= LOAD_ST_IDLE;
                endcase
            end
        end
    end

    assign bus.load_req          = load_req_q;
    assign bus.uart_disable      = uart_disable_q;
    // A grant lost during the write cycle suppresses that write.
    assign bus.uart_write_enable = write_q && bus.load_grant;
    assign bus.uart_data         = data_q;
    assign bus.uart_addr         = addr_q;
    assign bus.pc_reset          = pc_reset_q;
    assign bus.busy              = busy_q;
    assign bus.error             = error_q;
    assign bus.words_loaded      = words_q;

endmodule

// File: tb/tb_uart_load_controller.sv
// Randomized bench for uart_load_controller: expected memory writes come from
// the list of words the bench sends, checked against a write/pc_reset monitor.
module tb_uart_load_controller;
    import uart_load_controller_pkg::*;

    localparam int R    = 6;
    localparam int W    = 32;
    localparam int TMO  = 50;
    localparam int MAXN = 1 << (R + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int pc_cnt   = 0;
    int pc_cyc   = 0;
    int wr_cyc   = 0;
    int wr_addr[$];
    logic [W-1:0] wr_data[$];
    logic [W-1:0] exp_words[$];

    uart_load_controller_if #(.ROM_DEPTH(R), .ISA_WIDTH(W)) bus ();

    uart_load_controller #(
        .ROM_DEPTH      (R),
        .ISA_WIDTH      (W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory-side monitor, sampled just after each active edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.uart_write_enable) begin
            wr_addr.push_back(int'(bus.uart_addr));
            wr_data.push_back(bus.uart_data);
            wr_cyc = cyc;
        end
        if (bus.pc_reset) begin
            pc_cnt++;
            pc_cyc = cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic reset_monitor();
        wr_addr.delete();
        wr_data.delete();
        pc_cnt = 0;
        pc_cyc = 0;
        wr_cyc = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit noise);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        if (noise) bus.start_load = ($urandom_range(0, 3) == 0);
        tick();
        bus.rx_valid   = 1'b0;
        bus.start_load = 1'b0;
    endtask

    task automatic idle(input int gap_max);
        repeat ($urandom_range(0, gap_max)) tick();
    endtask

    task automatic fill_words(input int n);
        exp_words.delete();
        for (int i = 0; i < n; i++) exp_words.push_back($urandom());
    endtask

    task automatic start_and_grant();
        reset_monitor();
        bus.start_load = 1'b1;
        tick();
        bus.start_load = 1'b0;
        check("req_load_req", bus.load_req, 1);
        check("req_clears_error", bus.error, 0);
        check("req_clears_words", bus.words_loaded, 0);
        check("req_pipe_owns_mem", bus.uart_disable, 1);
        repeat (3) tick();
        check("req_holds_load_req", bus.load_req, 1);
        bus.load_grant = 1'b1;
        tick();
        check("hdr_upload_owns_mem", bus.uart_disable, 0);
    endtask

    task automatic finish_load(input int n);
        int waited;
        waited = 0;
        while (bus.busy && waited < 20) begin
            tick();
            waited++;
        end
        check("done_reached", bus.busy, 0);
        check("write_count", wr_addr.size(), n);
        for (int i = 0; i < wr_addr.size() && i < n; i++) begin
            check($sformatf("write_addr[%0d]", i), wr_addr[i], i);
            check($sformatf("write_data[%0d]", i), wr_data[i], exp_words[i]);
        end
        check("pc_reset_pulses", pc_cnt, 1);
        if (n > 0) check("pc_reset_after_last_write", pc_cyc, wr_cyc + 1);
        check("words_loaded", bus.words_loaded, n);
        check("idle_pipe_owns_mem", bus.uart_disable, 1);
        check("idle_load_req", bus.load_req, 0);
        check("idle_no_error", bus.error, 0);
        bus.load_grant = 1'b0;
    endtask

    task automatic run_load(input int n, input int gap_max, input bit noise);
        logic [15:0] len;
        len = 16'(n);
        start_and_grant();
        send_byte(len[7:0], 1'b0);
        idle(gap_max);
        send_byte(len[15:8], 1'b0);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                idle(gap_max);
                send_byte(8'(exp_words[i] >> (8 * k)), noise);
            end
        end
        finish_load(n);
    endtask

    initial begin
        bus.start_load = 1'b0;
        bus.load_grant = 1'b0;
        bus.rx_valid   = 1'b0;
        bus.rx_data    = '0;
        repeat (3) tick();
        check("rst_uart_disable", bus.uart_disable, 1);
        check("rst_load_req", bus.load_req, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_error", bus.error, 0);
        check("rst_write_enable", bus.uart_write_enable, 0);
        check("rst_pc_reset", bus.pc_reset, 0);
        check("rst_words_loaded", bus.words_loaded, 0);
        check("rst_uart_data", bus.uart_data, 0);
        check("rst_uart_addr", bus.uart_addr, 0);
        rst_n = 1'b1;
        tick();

        // Directed two-word download
        exp_words.delete();
        exp_words.push_back(32'h12345678);
        exp_words.push_back(32'hDEADBEEF);
        run_load(2, 0, 1'b0);

        // Stray bytes while idle must not start anything
        send_byte(8'h05, 1'b0);
        send_byte(8'h00, 1'b0);
        check("idle_bytes_dropped", bus.busy, 0);

        repeat (4) begin
            int n;
            n = $urandom_range(1, 8);
            fill_words(n);
            run_load(n, 2, 1'b0);
        end

        // Empty download
        exp_words.delete();
        run_load(0, 2, 1'b0);

        // Largest legal download, byte every cycle, start_load noise while busy
        fill_words(MAXN);
        run_load(MAXN, 0, 1'b1);
        check("data_region_addr_msb", (wr_addr.size() > MAXN / 2) ? ((wr_addr[MAXN / 2] >> R) & 1) : 0, 1);

        // Oversize header
        start_and_grant();
        send_byte(8'(MAXN + 1), 1'b0);
        send_byte(8'((MAXN + 1) >> 8), 1'b0);
        check("oversize_error", bus.error, 1);
        check("oversize_pipe_owns_mem", bus.uart_disable, 1);
        check("oversize_load_req", bus.load_req, 0);
        check("oversize_busy", bus.busy, 0);
        repeat (3) tick();
        check("oversize_no_write", wr_addr.size(), 0);
        check("oversize_no_pc_reset", pc_cnt, 0);
        bus.load_grant = 1'b0;

        // Idle timeout mid-word
        start_and_grant();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        repeat (TMO - 1) tick();
        check("timeout_not_early", bus.error, 0);
        tick();
        check("timeout_error", bus.error, 1);
        check("timeout_pipe_owns_mem", bus.uart_disable, 1);
        check("timeout_load_req", bus.load_req, 0);
        check("timeout_no_write", wr_addr.size(), 0);
        check("timeout_no_pc_reset", pc_cnt, 0);
        bus.load_grant = 1'b0;
        tick();
        exp_words.delete();
        run_load(0, 0, 1'b0);

        // Grant dropped mid-word
        start_and_grant();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        bus.load_grant = 1'b0;
        tick();
        check("grant_drop_error", bus.error, 1);
        check("grant_drop_pipe_owns_mem", bus.uart_disable, 1);
        repeat (3) tick();
        check("grant_drop_no_write", wr_addr.size(), 0);
        check("grant_drop_no_pc_reset", pc_cnt, 0);

        // Asynchronous reset during the write cycle
        start_and_grant();
        send_byte(8'h04, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int k = 0; k < 4; k++) send_byte(8'h30 + 8'(k), 1'b0);
        check("write_strobe_before_reset", bus.uart_write_enable, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_write_enable", bus.uart_write_enable, 0);
        check("async_rst_uart_disable", bus.uart_disable, 1);
        check("async_rst_load_req", bus.load_req, 0);
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_words_loaded", bus.words_loaded, 0);
        reset_monitor();
        tick();
        tick();
        check("in_reset_no_write", wr_addr.size(), 0);
        rst_n = 1'b1;
        bus.load_grant = 1'b0;
        tick();
        check("post_reset_idle", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_load_controller.md
Name: uart_load_controller

Overview:
Sequences a UART program/data download into the instruction and data memories, then restarts execution.
- Obtains a grant from hazard_unit before touching memory.
- Parses a length header from the UART byte stream and packs bytes into 32-bit words.
- Drives the memory upload port (uart_disable, uart_write_enable, uart_data, uart_addr).
- Pulses pc_reset on successful completion.
- Sits between the UART receiver and the IF-stage memory / hazard_unit.

Parameters:
ROM_DEPTH, 14, word-address width of one memory; upload address is ROM_DEPTH+1 bits (MSB=1 selects data memory)
ISA_WIDTH, 32, word width
TIMEOUT_CYCLES, 10000000, max idle cycles between bytes once granted

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_load  in  1  one-cycle request to begin a download (debug button/command)
load_grant  in  1  from hazard_unit; pipeline drained, memory writes allowed
rx_valid  in  1  one-cycle strobe, rx_data holds a received byte
rx_data  in  8  received byte
load_req  out  1  to hazard_unit; request/hold memory ownership
uart_disable  out  1  1 = pipeline owns memory; 0 = upload owns memory
uart_write_enable  out  1  one-cycle word write strobe
uart_data  out  ISA_WIDTH  assembled word
uart_addr  out  ROM_DEPTH+1  word index
pc_reset  out  1  one-cycle pulse restarting PC at 0
busy  out  1  high in any state except IDLE and ERROR
error  out  1  sticky abort flag
words_loaded  out  ROM_DEPTH+2  words written in current/last download

Behaviour:
- Reset values:
  - uart_disable=1, load_req=0, all other outputs 0.
  - State IDLE, byte/word counters 0, timer 0.
- States: IDLE, REQ, HDR0, HDR1, DATA, WRITE, DONE, ERROR.
- IDLE/ERROR --start_load--> REQ.
  - Clears error and words_loaded.
  - start_load is ignored in every other state.
- REQ:
  - load_req=1; wait indefinitely for load_grant.
  - On grant -> HDR0; uart_disable=0 from the HDR0 cycle onward.
- HDR0: first rx byte = N[7:0] -> HDR1.
- HDR1: next rx byte = N[15:8].
  - N==0 -> DONE.
  - N > 2^(ROM_DEPTH+1) -> ERROR.
  - Otherwise -> DATA.
- DATA:
  - Bytes are little-endian; byte k of the word goes to bits [8k+7:8k].
  - After the 4th byte -> WRITE.
- WRITE (exactly one cycle):
  - uart_write_enable=1; uart_addr = word index; uart_data = packed word; all stable this cycle.
  - Word index and words_loaded increment at the end of the cycle.
  - If index+1==N -> DONE, else -> DATA.
  - An rx_valid arriving during WRITE is captured as byte 0 of the next word; no byte is lost.
- DONE (one cycle):
  - pc_reset=1, uart_disable=0, load_req=1.
  - Next cycle: IDLE with uart_disable=1, load_req=0.
- Timeout:
  - Timer clears on every rx_valid and on entry to HDR0.
  - It increments in HDR0/HDR1/DATA.
  - Reaching TIMEOUT_CYCLES -> ERROR.
  - rx_valid in the same cycle as expiry wins: the byte is accepted and the timer cleared.
- Grant loss: load_grant falling in HDR0..DATA/WRITE -> ERROR. No write is issued in that cycle.
- ERROR:
  - error=1, uart_disable=1, load_req=0.
  - No pc_reset; partially written memory is left as is.
- Address-space wrap: impossible, because the N bound is checked in HDR1.
- rx_valid in IDLE/REQ/DONE/ERROR is dropped.
- Async reset mid-download returns to reset values immediately. No write strobe can be emitted after rst_n falls.

Decomposition:
- Shared definitions file gets:
  - state encodings (LOAD_ST_*, 3 bits);
  - UART_BYTE_WIDTH=8;
  - LOAD_LEN_WIDTH=16.
- ISA_WIDTH and ROM_DEPTH come from the existing definitions.
- One natural sub-module: uart_word_packer (byte counter + shift register; outputs word and word_ready). Timer and FSM stay in the top.

Test Plan:
- Normal load: start_load, grant after 3 cycles, bytes 02 00 | 78 56 34 12 | EF BE AD DE
  - -> writes 0x12345678@0 then 0xDEADBEEF@1;
  - -> pc_reset pulse 1 cycle after second write; words_loaded=2; uart_disable back to 1.
- Data-memory region: N=1 preceded by enough dummy words that index=2^ROM_DEPTH -> uart_addr MSB=1 on that write.
- Empty/oversize header:
  - N=0 -> DONE with zero writes, pc_reset pulses.
  - N=2^(ROM_DEPTH+1)+1 -> ERROR, no write, no pc_reset.
- Timeout: stop after 2 data bytes, TIMEOUT_CYCLES=50 in bench
  - -> ERROR on cycle 50, error=1, uart_disable=1;
  - -> a new start_load clears error.
- Grant drop: deassert load_grant mid-word -> ERROR next cycle, no uart_write_enable, no pc_reset.
- Back-to-back bytes: rx_valid every cycle including the WRITE cycle -> all words correct; start_load pulses during busy ignored.
